// File: rtl/qam16_mixer.sv
// QAM16 symbol mixer: Gray-maps 4-bit symbols to I/Q levels, holds each for a
// fixed number of NCO samples and forms the passband sample I*cos - Q*sin.
module qam16_mixer #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int NCO_W           = 10,
    parameter int OUT_W           = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nco_valid,
    input  logic signed [NCO_W-1:0] sin,
    input  logic signed [NCO_W-1:0] cos,
    input  logic                    sym_valid,
    input  logic [3:0]              sym,
    output logic                    sym_ready,
    output logic                    mod_valid,
    output logic signed [OUT_W-1:0] mod_out,
    output logic                    underrun
);

    localparam int CNT_W  = $clog2(SAMPLES_PER_SYM);
    localparam int PROD_W = NCO_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Gray code 00,01,11,10 walks the constellation axis -3,-1,+1,+3.
    function automatic logic signed [2:0] gray_level(input logic [1:0] code);
        logic signed [2:0] lvl;
        case (code)
            2'b00:   lvl = 3'sb101;
            2'b01:   lvl = 3'sb111;
            2'b11:   lvl = 3'sb001;
            2'b10:   lvl = 3'sb011;
            default: lvl = 3'sb000;
        endcase
        return lvl;
    endfunction

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [2:0]        i_lvl_r;
    logic signed [2:0]        q_lvl_r;
    logic signed [PROD_W-1:0] pi_r;
    logic signed [PROD_W-1:0] pq_r;
    logic                     v1_r;
    logic signed [OUT_W-1:0]  mod_out_r;
    logic                     mod_valid_r;
    logic                     underrun_r;

    logic                     sym_ready_s;
    logic                     last_s;
    logic                     accept_s;
    logic                     run_sample_s;
    logic signed [PROD_W-1:0] pi_s;
    logic signed [PROD_W-1:0] pq_s;
    logic signed [OUT_W-1:0]  diff_s;

    assign last_s       = (cnt_r == CNT_LAST);
    assign accept_s     = sym_valid && sym_ready_s;
    assign run_sample_s = nco_valid && (state_r == ST_RUN);

    // Ready is open in IDLE and on the final sample of a symbol so the next
    // symbol can slot in without a gap; held low while reset is asserted.
    always_comb begin
        sym_ready_s = 1'b0;
        if (!rst) begin
            sym_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: sym_ready_s = 1'b1;
                ST_RUN:  sym_ready_s = nco_valid && last_s;
                default: sym_ready_s = 1'b0;
            endcase
        end
    end

    // Signed products and difference, sign-extended before each operation.
    always_comb begin
        pi_s   = PROD_W'(i_lvl_r) * PROD_W'(cos);
        pq_s   = PROD_W'(q_lvl_r) * PROD_W'(sin);
        diff_s = OUT_W'(pi_r) - OUT_W'(pq_r);
    end

    // Symbol sequencing FSM: level registers, sample counter, underrun pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            i_lvl_r    <= 3'sb000;
            q_lvl_r    <= 3'sb000;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        i_lvl_r <= gray_level(sym[3:2]);
                        q_lvl_r <= gray_level(sym[1:0]);
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (nco_valid) begin
                        if (!last_s) begin
                            cnt_r <= cnt_r + CNT_W'(1'b1);
                        end else if (accept_s) begin
                            i_lvl_r <= gray_level(sym[3:2]);
                            q_lvl_r <= gray_level(sym[1:0]);
                            cnt_r   <= '0;
                        end else begin
                            cnt_r      <= '0;
                            state_r    <= ST_IDLE;
                            underrun_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Pipeline stage 1: register the two partial products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pi_r <= '0;
            pq_r <= '0;
            v1_r <= 1'b0;
        end else begin
            v1_r <= run_sample_s;
            if (run_sample_s) begin
                pi_r <= pi_s;
                pq_r <= pq_s;
            end else begin
                pi_r <= pi_r;
                pq_r <= pq_r;
            end
        end
    end

    // Pipeline stage 2: register the difference; output holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_out_r   <= '0;
            mod_valid_r <= 1'b0;
        end else begin
            mod_valid_r <= v1_r;
            if (v1_r) begin
                mod_out_r <= diff_s;
            end else begin
                mod_out_r <= mod_out_r;
            end
        end
    end

    assign sym_ready = sym_ready_s;
    assign mod_valid = mod_valid_r;
    assign mod_out   = mod_out_r;
    assign underrun  = underrun_r;

endmodule

// Protocol checker for qam16_mixer outputs; instantiated alongside the mixer.
module qam16_mixer_chk #(
    parameter int NCO_W = 10,
    parameter int OUT_W = 13
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    sym_ready,
    input logic                    mod_valid,
    input logic signed [OUT_W-1:0] mod_out,
    input logic                    underrun
);

    localparam int LIMIT = 6 * (2 ** (NCO_W - 1));

    a_ready_low_in_reset: assert property (@(posedge clk) !rst |-> !sym_ready);

    a_underrun_single: assert property (@(posedge clk) disable iff (!rst)
        underrun |=> !underrun);

    a_underrun_idle: assert property (@(posedge clk) disable iff (!rst)
        underrun |-> sym_ready);

    a_out_range: assert property (@(posedge clk) disable iff (!rst)
        mod_valid |-> ((int'(mod_out) <= LIMIT) && (int'(mod_out) >= -LIMIT)));

endmodule

// File: tb/tb_qam16_mixer.sv
// Scoreboard bench for qam16_mixer: a sample-level reference model queues
// expected outputs with their arrival cycle; a monitor pops and compares.
module tb_qam16_mixer;

    localparam int SPS   = 4;
    localparam int NCO_W = 10;
    localparam int OUT_W = 13;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    nco_valid;
    logic signed [NCO_W-1:0] sin;
    logic signed [NCO_W-1:0] cos;
    logic                    sym_valid;
    logic [3:0]              sym;
    logic                    sym_ready;
    logic                    mod_valid;
    logic signed [OUT_W-1:0] mod_out;
    logic                    underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit tb_run = 1'b0;

    exp_t       q[$];
    logic [3:0] pend[$];
    int         lvl_tab[4] = '{-3, -1, 3, 1};
    int         rem        = 0;
    int         li         = 0;
    int         lq         = 0;
    bit         exp_under  = 1'b0;
    int         last_exp   = 0;

    qam16_mixer #(.SAMPLES_PER_SYM(SPS), .NCO_W(NCO_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .nco_valid(nco_valid), .sin(sin), .cos(cos),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .mod_valid(mod_valid), .mod_out(mod_out), .underrun(underrun)
    );

    qam16_mixer_chk #(.NCO_W(NCO_W), .OUT_W(OUT_W)) chk (
        .clk(clk), .rst(rst), .sym_ready(sym_ready), .mod_valid(mod_valid),
        .mod_out(mod_out), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (tb_run) begin
            if (mod_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid at cycle %0d: got mod_out %0d, expected no output",
                             cyc, int'(mod_out));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("mod_out", int'(mod_out), e.val);
                    check("latency", cyc, e.cyc);
                    last_exp = e.val;
                end
            end else begin
                check("mod_out_hold", int'(mod_out), last_exp);
            end
        end
    end

    // One clock of stimulus; the model decides readiness on its own terms.
    task automatic cycle(input bit nv, input int s, input int c);
        bit         sv;
        bit         er;
        bit         acc;
        bit         un_next;
        logic [3:0] sy;
        sv = (pend.size() > 0);
        sy = sv ? pend[0] : 4'h0;
        nco_valid = nv;
        sin       = NCO_W'(s);
        cos       = NCO_W'(c);
        sym_valid = sv;
        sym       = sy;
        #1;
        er = (rem == 0) || (nv && rem == 1);
        check("sym_ready", int'(sym_ready), int'(er));
        check("underrun", int'(underrun), int'(exp_under));
        acc     = sv && er;
        un_next = 1'b0;
        if (nv && rem > 0) begin
            q.push_back('{li * c - lq * s, cyc + 2});
            rem--;
            if (rem == 0 && !acc) un_next = 1'b1;
        end
        if (acc) begin
            li  = lvl_tab[sy[3:2]];
            lq  = lvl_tab[sy[1:0]];
            rem = SPS;
            void'(pend.pop_front());
        end
        exp_under = un_next;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ncyc, input int nv_pct, input bit alt,
                       input bit rnd, input int s_fix, input int c_fix);
        for (int k = 0; k < ncyc; k++) begin
            bit nv;
            int s;
            int c;
            nv = alt ? (k % 2 == 0) : (int'($urandom_range(99)) < nv_pct);
            s  = rnd ? int'($urandom_range(1023)) - 512 : s_fix;
            c  = rnd ? int'($urandom_range(1023)) - 512 : c_fix;
            cycle(nv, s, c);
        end
    endtask

    // Asynchronous reset between edges: outputs must clear before any clock.
    task automatic do_reset();
        nco_valid = 1'b1;
        sym_valid = 1'b1;
        rst       = 1'b0;
        q.delete();
        pend.delete();
        rem       = 0;
        exp_under = 1'b0;
        last_exp  = 0;
        #1;
        check("rst_sym_ready", int'(sym_ready), 0);
        check("rst_mod_valid", int'(mod_valid), 0);
        check("rst_mod_out", int'(mod_out), 0);
        check("rst_underrun", int'(underrun), 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        sym_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        nco_valid = 1'b0;
        sin       = '0;
        cos       = '0;
        sym_valid = 1'b0;
        sym       = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        tb_run = 1'b1;
        check("init_sym_ready", int'(sym_ready), 0);
        check("init_mod_valid", int'(mod_valid), 0);
        check("init_mod_out", int'(mod_out), 0);
        check("init_underrun", int'(underrun), 0);
        rst = 1'b1;

        // Carrier running with no symbol: idle, ready, silent.
        run(10, 100, 1'b0, 1'b0, 37, -81);

        // Single symbol, +3/+3 levels: 300 - 150 = 150, then underrun.
        pend.push_back(4'b1010);
        run(10, 100, 1'b0, 1'b0, 50, 100);

        // Extreme levels and samples: -1533 - 1536 = -3069.
        pend.push_back(4'b0000);
        run(10, 100, 1'b0, 1'b0, -512, 511);

        // Back-to-back symbols: four +200 then four -200 with no gap.
        pend.push_back(4'b1111);
        pend.push_back(4'b0101);
        run(14, 100, 1'b0, 1'b0, 0, 200);

        // Alternating carrier valid stretches the symbol but not its length.
        pend.push_back(4'(($urandom_range(15))));
        run(14, 0, 1'b1, 1'b1, 0, 0);

        // Reset during the second sample of a symbol.
        pend.push_back(4'b1101);
        run(2, 100, 1'b0, 1'b0, 120, -300);
        do_reset();
        run(10, 100, 1'b0, 1'b1, 0, 0);

        // Randomized traffic with gaps in both carrier and symbol supply.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(12)) + 1;
            for (int j = 0; j < n; j++) pend.push_back(4'(($urandom_range(15))));
            run(int'($urandom_range(40)) + 20, int'($urandom_range(60)) + 40, 1'b0, 1'b1, 0, 0);
        end

        // Drain: stop feeding symbols and let the pipeline empty.
        pend.delete();
        run(4 * SPS + 8, 100, 1'b0, 1'b1, 0, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
